// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) always wins, long-latency results (B)
// are buffered in a FIFO and drained into idle cycles. Optional counters under RF_ARB_STATS_EN.
module rf_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_we,
    input  logic [4:0]  a_waddr,
    input  logic [31:0] a_wdata,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_waddr,
    input  logic [31:0] b_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic [31:0] pending,
`ifdef RF_ARB_STATS_EN
    output logic [31:0] stat_a_wr,
    output logic [31:0] stat_b_wr,
    output logic [31:0] stat_stall,
`endif
    output logic        a_conflict
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = 8;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } b_entry_t;

    b_entry_t          mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starve_cnt;

    logic [AW-1:0]     rd_ptr_n;
    logic [AW-1:0]     wr_ptr_n;
    logic [CW-1:0]     count_n;
    logic [SW-1:0]     starve_n;
    logic              stall_n;
    logic              conflict_n;
    logic [31:0]       pending_n;

    logic              a_wins;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    b_entry_t          head;
    b_entry_t          ent;
    logic [AW-1:0]     idx;

    // Same-cycle arbitration and write-port drive
    always_comb begin
        a_wins   = a_we && (a_waddr != 5'd0);
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        head     = mem[rd_ptr];
        b_ready  = !rst && !full;
        push     = b_valid && b_ready;
        pop      = !rst && !a_wins && !empty;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!rst) begin
            if (a_wins) begin
                rf_we    = 1'b1;
                rf_waddr = a_waddr;
                rf_wdata = a_wdata;
            end else if (!empty) begin
                rf_we    = (head.addr != 5'd0);
                rf_waddr = head.addr;
                rf_wdata = head.data;
            end
        end
    end

    // Next-state: pointers, starvation, and the pending mask of the post-edge FIFO contents
    always_comb begin
        rd_ptr_n   = rd_ptr + AW'(pop);
        wr_ptr_n   = wr_ptr + AW'(push);
        count_n    = count + CW'(push) - CW'(pop);
        starve_n   = starve_cnt;
        conflict_n = a_conflict | (a_wins & stall_req);
        pending_n  = 32'd0;
        idx        = '0;
        ent        = '0;

        if (empty || pop) begin
            starve_n = '0;
        end else if (a_wins && (starve_cnt != SW'(STARVE_LIMIT))) begin
            starve_n = starve_cnt + SW'(1);
        end
        stall_n = (starve_n == SW'(STARVE_LIMIT));

        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_n + AW'(i);
            ent = (push && (idx == wr_ptr)) ? b_entry_t'{addr: b_waddr, data: b_wdata} : mem[idx];
            if (CW'(i) < count_n) begin
                pending_n[ent.addr] = 1'b1;
            end
        end
        pending_n[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            a_conflict <= 1'b0;
            pending    <= 32'd0;
        end else begin
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            count      <= count_n;
            starve_cnt <= starve_n;
            stall_req  <= stall_n;
            a_conflict <= conflict_n;
            pending    <= pending_n;
        end
    end

    // Storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= b_entry_t'{addr: b_waddr, data: b_wdata};
        end
    end

`ifdef RF_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_a_wr  <= 32'd0;
            stat_b_wr  <= 32'd0;
            stat_stall <= 32'd0;
        end else begin
            if (a_wins) begin
                stat_a_wr <= stat_a_wr + 32'd1;
            end
            if (pop && (head.addr != 5'd0)) begin
                stat_b_wr <= stat_b_wr + 32'd1;
            end
            if (stall_req) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed + randomized bench for rf_write_arbiter against a queue-based reference model.
module tb_rf_write_arbiter;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [31:0] pending;
    logic        a_conflict;
`ifdef RF_ARB_STATS_EN
    logic [31:0] stat_a_wr;
    logic [31:0] stat_b_wr;
    logic [31:0] stat_stall;
`endif

    always #5 clk = ~clk;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .pending(pending),
`ifdef RF_ARB_STATS_EN
        .stat_a_wr(stat_a_wr), .stat_b_wr(stat_b_wr), .stat_stall(stat_stall),
`endif
        .a_conflict(a_conflict)
    );

    // Reference model: FIFO as a queue of {addr, data}, plus starvation/stall/conflict state
    logic [36:0] q[$];
    int          starve_m   = 0;
    bit          stall_m    = 1'b0;
    bit          conflict_m = 1'b0;
    bit          last_acc   = 1'b0;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit awe, input logic [4:0] aa, input logic [31:0] ad,
                         input bit bv, input logic [4:0] ba, input logic [31:0] bd);
        rst     = r;
        a_we    = awe;
        a_waddr = aa;
        a_wdata = ad;
        b_valid = bv;
        b_waddr = ba;
        b_wdata = bd;
    endtask

    // Check outputs mid-cycle, then advance the model across the rising edge
    task automatic cycle();
        bit          a_w;
        bit          acc;
        bit          pop;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] pend;
        logic [36:0] h;
        @(negedge clk);
        a_w    = a_we && (a_waddr != 5'd0);
        e_we   = 1'b0;
        e_addr = 5'd0;
        e_data = 32'd0;
        if (!rst) begin
            if (a_w) begin
                e_we   = 1'b1;
                e_addr = a_waddr;
                e_data = a_wdata;
            end else if (q.size() > 0) begin
                h      = q[0];
                e_we   = (h[36:32] != 5'd0);
                e_addr = h[36:32];
                e_data = h[31:0];
            end
        end
        pend = 32'd0;
        foreach (q[i]) begin
            h = q[i];
            pend[h[36:32]] = 1'b1;
        end
        pend[0] = 1'b0;
        chk("rf_we", 32'(rf_we), 32'(e_we));
        chk("b_ready", 32'(b_ready), 32'(!rst && (q.size() < DEPTH)));
        if (!rst) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
            chk("rf_wdata", rf_wdata, e_data);
        end
        chk("pending", pending, pend);
        chk("stall_req", 32'(stall_req), 32'(stall_m));
        chk("a_conflict", 32'(a_conflict), 32'(conflict_m));

        @(posedge clk);
        if (rst) begin
            q.delete();
            starve_m   = 0;
            stall_m    = 1'b0;
            conflict_m = 1'b0;
            last_acc   = 1'b0;
        end else begin
            acc = b_valid && (q.size() < DEPTH);
            pop = !a_w && (q.size() > 0);
            if (a_w && stall_m) conflict_m = 1'b1;
            if ((q.size() > 0) && a_w)
                starve_m = (starve_m < STARVE_LIMIT) ? starve_m + 1 : starve_m;
            else
                starve_m = 0;
            stall_m = (starve_m == STARVE_LIMIT);
            if (pop) void'(q.pop_front());
            if (acc) q.push_back({b_waddr, b_wdata});
            last_acc = acc;
        end
        #1;
    endtask

    initial begin
        bit          got5;
        bit          r;
        bit          awe;
        bit          bv;
        logic [4:0]  aa;
        logic [4:0]  ba;
        logic [31:0] ad;
        logic [31:0] bd;

        // Reset, then idle
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (10) cycle();

        // A only, then A to x0
        drive(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        cycle();
        drive(0, 1, 5'd0, 32'h11111111, 0, 0, 0);
        cycle();

        // B into idle port
        drive(0, 0, 0, 0, 1, 5'd7, 32'h12345678);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle();

        // Fill FIFO under continuous A, 5th beat held
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 5'(i + 1), 32'hA0000000 + 32'(i), 1, 5'(i + 10), 32'hB0000000 + 32'(i));
            cycle();
        end
        got5 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, !got5, 5'd14, 32'hB0000004);
            cycle();
            if (last_acc) got5 = 1'b1;
        end

        // Starvation, conflict, then drain
        drive(0, 1, 5'd3, 32'hC0, 1, 5'd9, 32'h99999999);
        cycle();
        drive(0, 1, 5'd3, 32'hC1, 0, 0, 0);
        repeat (STARVE_LIMIT) cycle();
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        // Reset mid-operation with 3 buffered entries
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 5'd4, 32'hE0 + 32'(i), 1, 5'(20 + i), 32'hF0 + 32'(i));
            cycle();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) cycle();

        // Randomized traffic; pipeline honours stall_req
        for (int n = 0; n < 500; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            awe = !stall_m && ($urandom_range(0, 2) != 0);
            aa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ad  = $urandom;
            bv  = ($urandom_range(0, 1) == 1);
            ba  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bd  = $urandom;
            drive(r, awe, aa, ad, bv, ba, bd);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
